alu_exec_stage: RTL and testbench

Execute stage directly downstream of the register file. Consumes the two read operands plus a decoded opcode and destination, computes the result, and drives the register file write port (regwrite, writereg, writedata) one or more cycles later. Single-cycle ALU ops plus an iterative shift-add multiplier, with a valid/ready handshake toward decode.

---
 rtl/alu_exec_stage.sv | 250 +++++++++++++++++++++++++
 tb/tb_alu_exec_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
//
// Execute stage sitting right after the register file. Takes the two read
// operands, a decoded opcode and a destination register, computes the result
// and drives the register-file write port one or more cycles later.
//
// Single-cycle ops: ADD, SUB, AND, OR, XOR, SHL, SHR (result registered, so it
// appears the cycle after accept; back-to-back accepts are allowed).
// Opcode 111 depends on the build:
//   MUL_EN defined   : unsigned iterative shift-add multiplier, one multiplier
//                      bit per cycle, WIDTH iterations, stage busy meanwhile.
//   MUL_EN undefined : single-cycle MOV (writedata = data1), never busy.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   reset      in   synchronous active-low reset
//   in_valid   in   decode presents an operation
//   in_ready   out  stage can accept an operation this cycle
//   opcode     in   3-bit operation select
//   data1      in   operand A
//   data2      in   operand B
//   destreg    in   destination register
//   wr_en_in   in   operation writes back when 1
//   regwrite   out  one-cycle write strobe to the register file
//   writereg   out  write address
//   writedata  out  write data
//   zero       out  last completed result was zero
//   carry      out  carry/borrow of the last completed ADD/SUB
//   busy       out  multiplier iteration in progress
// -----------------------------------------------------------------------------
module alu_exec_stage #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        opcode,
  input  logic [WIDTH-1:0]  data1,
  input  logic [WIDTH-1:0]  data2,
  input  logic [ADDR_W-1:0] destreg,
  input  logic              wr_en_in,
  output logic              regwrite,
  output logic [ADDR_W-1:0] writereg,
  output logic [WIDTH-1:0]  writedata,
  output logic              zero,
  output logic              carry,
  output logic              busy
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  // Write-port and flag registers
  logic              regwrite_q,  regwrite_d;
  logic [ADDR_W-1:0] writereg_q,  writereg_d;
  logic [WIDTH-1:0]  writedata_q, writedata_d;
  logic              zero_q,      zero_d;
  logic              carry_q,     carry_d;

  // Single-cycle ALU result
  logic [WIDTH:0]    sumExt;
  logic [WIDTH:0]    diffExt;
  logic [WIDTH-1:0]  aluResult;
  logic              aluSetsCarry;
  logic              aluCarry;
  logic              accept;

  // Combinational ALU on the live operands. The extra top bit of the
  // subtraction is the borrow, which is exactly data1 < data2 for unsigned.
  always_comb begin
    sumExt       = {1'b0, data1} + {1'b0, data2};
    diffExt      = {1'b0, data1} - {1'b0, data2};
    aluResult    = data1;
    aluSetsCarry = 1'b0;
    aluCarry     = 1'b0;
    case (opcode)
      OP_ADD: begin
        aluResult    = sumExt[WIDTH-1:0];
        aluSetsCarry = 1'b1;
        aluCarry     = sumExt[WIDTH];
      end
      OP_SUB: begin
        aluResult    = diffExt[WIDTH-1:0];
        aluSetsCarry = 1'b1;
        aluCarry     = diffExt[WIDTH];
      end
      OP_AND:  aluResult = data1 & data2;
      OP_OR:   aluResult = data1 | data2;
      OP_XOR:  aluResult = data1 ^ data2;
      OP_SHL:  aluResult = data1 << data2[2:0];
      OP_SHR:  aluResult = data1 >> data2[2:0];
      OP_MUL:  aluResult = data1;
      default: aluResult = data1;
    endcase
  end

  assign accept = in_valid & in_ready;

`ifdef MUL_EN
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t            state_q,  state_d;
  logic [WIDTH-1:0]  accum_q,  accum_d;
  logic [WIDTH-1:0]  mcand_q,  mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [ADDR_W-1:0] mulDest_q, mulDest_d;
  logic              mulWen_q,  mulWen_d;
  logic [WIDTH-1:0]  accumNext;

  // Only the low WIDTH product bits are kept, so the multiplicand can simply
  // shift left out of range as the iterations proceed.
  assign accumNext = mplier_q[0] ? (accum_q + mcand_q) : accum_q;

  assign in_ready = (state_q == S_IDLE);
  assign busy     = (state_q == S_MUL);

  // Next-state and datapath control. IDLE completes single-cycle ops or
  // loads the multiplier; MUL runs WIDTH iterations and writes back on the
  // last one so the result shows up the cycle in_ready returns.
  always_comb begin
    state_d     = state_q;
    accum_d     = accum_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    mulDest_d   = mulDest_q;
    mulWen_d    = mulWen_q;
    regwrite_d  = 1'b0;
    writereg_d  = writereg_q;
    writedata_d = writedata_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (opcode == OP_MUL) begin
            state_d   = S_MUL;
            accum_d   = '0;
            mcand_d   = data1;
            mplier_d  = data2;
            cnt_d     = '0;
            mulDest_d = destreg;
            mulWen_d  = wr_en_in;
          end else begin
            regwrite_d  = wr_en_in;
            writereg_d  = destreg;
            writedata_d = aluResult;
            zero_d      = (aluResult == '0);
            if (aluSetsCarry) carry_d = aluCarry;
          end
        end
      end
      S_MUL: begin
        accum_d  = accumNext;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d     = S_IDLE;
          regwrite_d  = mulWen_q;
          writereg_d  = mulDest_q;
          writedata_d = accumNext;
          zero_d      = (accumNext == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Multiplier state; reset aborts any in-flight multiply.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      accum_q   <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      mulDest_q <= '0;
      mulWen_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      accum_q   <= accum_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      mulDest_q <= mulDest_d;
      mulWen_q  <= mulWen_d;
    end
  end
`else
  assign in_ready = 1'b1;
  assign busy     = 1'b0;

  // Every accepted op completes in one cycle; opcode 111 acts as MOV.
  always_comb begin
    regwrite_d  = 1'b0;
    writereg_d  = writereg_q;
    writedata_d = writedata_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    if (accept) begin
      regwrite_d  = wr_en_in;
      writereg_d  = destreg;
      writedata_d = aluResult;
      zero_d      = (aluResult == '0);
      if (aluSetsCarry) carry_d = aluCarry;
    end
  end
`endif

  // Register-file write port and status flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      regwrite_q  <= 1'b0;
      writereg_q  <= '0;
      writedata_q <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      regwrite_q  <= regwrite_d;
      writereg_q  <= writereg_d;
      writedata_q <= writedata_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
    end
  end

  assign regwrite  = regwrite_q;
  assign writereg  = writereg_q;
  assign writedata = writedata_q;
  assign zero      = zero_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_stage
//
// Self-checking bench for alu_exec_stage. A table of directed single-cycle
// operations is streamed back-to-back, followed by hand-written sequences for
// reset behaviour and (when MUL_EN is defined) the iterative multiplier.
// -----------------------------------------------------------------------------
module tb_alu_exec_stage;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        opcode;
  logic [WIDTH-1:0]  data1;
  logic [WIDTH-1:0]  data2;
  logic [ADDR_W-1:0] destreg;
  logic              wr_en_in;
  logic              regwrite;
  logic [ADDR_W-1:0] writereg;
  logic [WIDTH-1:0]  writedata;
  logic              zero;
  logic              carry;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  alu_exec_stage #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .data1     (data1),
    .data2     (data2),
    .destreg   (destreg),
    .wr_en_in  (wr_en_in),
    .regwrite  (regwrite),
    .writereg  (writereg),
    .writedata (writedata),
    .zero      (zero),
    .carry     (carry),
    .busy      (busy)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]        op;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [ADDR_W-1:0] dest;
    logic              wen;
    logic [WIDTH-1:0]  expData;
    logic              expZero;
    logic              expCarry;
  } vec_t;

`ifdef MUL_EN
  localparam int NV = 13;
`else
  localparam int NV = 14;
`endif

  vec_t vecs [NV];

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Drive one operation onto the decode-side inputs.
  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic [ADDR_W-1:0] d, input logic w);
    in_valid = v;
    opcode   = op;
    data1    = a;
    data2    = b;
    destreg  = d;
    wr_en_in = w;
  endtask

  initial begin
    // Expected values hand-computed; carry carries over through non-ADD/SUB ops.
    vecs[0]  = '{3'b000, 8'hF0, 8'h20, 3'd3, 1'b1, 8'h10, 1'b0, 1'b1};
    vecs[1]  = '{3'b001, 8'h05, 8'h05, 3'd1, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{3'b001, 8'h03, 8'h04, 3'd2, 1'b1, 8'hFF, 1'b0, 1'b1};
    vecs[3]  = '{3'b010, 8'hF0, 8'h3C, 3'd4, 1'b1, 8'h30, 1'b0, 1'b1};
    vecs[4]  = '{3'b011, 8'h0F, 8'h30, 3'd5, 1'b1, 8'h3F, 1'b0, 1'b1};
    vecs[5]  = '{3'b100, 8'hAA, 8'hAA, 3'd6, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[6]  = '{3'b101, 8'h81, 8'h09, 3'd7, 1'b1, 8'h02, 1'b0, 1'b1};
    vecs[7]  = '{3'b110, 8'h80, 8'h07, 3'd0, 1'b1, 8'h01, 1'b0, 1'b1};
    vecs[8]  = '{3'b000, 8'hFF, 8'h01, 3'd1, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[9]  = '{3'b000, 8'h12, 8'h34, 3'd2, 1'b1, 8'h46, 1'b0, 1'b0};
    vecs[10] = '{3'b110, 8'h01, 8'h01, 3'd3, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[11] = '{3'b100, 8'h5A, 8'h0F, 3'd4, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[12] = '{3'b101, 8'h01, 8'hFF, 3'd5, 1'b1, 8'h80, 1'b0, 1'b0};
`ifndef MUL_EN
    vecs[13] = '{3'b111, 8'hC3, 8'h11, 3'd6, 1'b1, 8'hC3, 1'b0, 1'b0};
`endif

    // Reset held low for two cycles.
    reset = 1'b0;
    applyStimulus(1'b0, 3'b000, 8'h00, 8'h00, 3'd0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("rst_regwrite", {31'd0, regwrite}, 32'd0);
    checkOutput("rst_writereg", {29'd0, writereg}, 32'd0);
    checkOutput("rst_writedata", {24'd0, writedata}, 32'd0);
    checkOutput("rst_zero", {31'd0, zero}, 32'd0);
    checkOutput("rst_carry", {31'd0, carry}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("idle_regwrite", {31'd0, regwrite}, 32'd0);

    // Stream the table back-to-back, one op per cycle.
    for (int i = 0; i < NV; i++) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest, vecs[i].wen);
      @(negedge clk);
      checkOutput($sformatf("v%0d_regwrite", i), {31'd0, regwrite}, {31'd0, vecs[i].wen});
      if (vecs[i].wen)
        checkOutput($sformatf("v%0d_writereg", i), {29'd0, writereg}, {29'd0, vecs[i].dest});
      checkOutput($sformatf("v%0d_writedata", i), {24'd0, writedata}, {24'd0, vecs[i].expData});
      checkOutput($sformatf("v%0d_zero", i), {31'd0, zero}, {31'd0, vecs[i].expZero});
      checkOutput($sformatf("v%0d_carry", i), {31'd0, carry}, {31'd0, vecs[i].expCarry});
      checkOutput($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
    end

    // No valid op: strobe drops, data holds the last result.
    applyStimulus(1'b0, 3'b000, 8'h77, 8'h11, 3'd2, 1'b1);
    @(negedge clk);
    checkOutput("hold_regwrite", {31'd0, regwrite}, 32'd0);
    checkOutput("hold_writedata", {24'd0, writedata}, {24'd0, vecs[NV-1].expData});

`ifdef MUL_EN
    // 13 * 11 = 143 = 0x8F; a pending ADD must wait until in_ready returns.
    applyStimulus(1'b1, 3'b111, 8'd13, 8'd11, 3'd5, 1'b1);
    @(negedge clk);
    applyStimulus(1'b1, 3'b000, 8'h01, 8'h02, 3'd6, 1'b1);
    for (int c = 0; c < WIDTH; c++) begin
      checkOutput($sformatf("mul_busy_c%0d", c), {31'd0, busy}, 32'd1);
      checkOutput($sformatf("mul_in_ready_c%0d", c), {31'd0, in_ready}, 32'd0);
      checkOutput($sformatf("mul_regwrite_c%0d", c), {31'd0, regwrite}, 32'd0);
      @(negedge clk);
    end
    checkOutput("mul_done_regwrite", {31'd0, regwrite}, 32'd1);
    checkOutput("mul_done_writereg", {29'd0, writereg}, 32'd5);
    checkOutput("mul_done_writedata", {24'd0, writedata}, 32'h8F);
    checkOutput("mul_done_zero", {31'd0, zero}, 32'd0);
    checkOutput("mul_done_busy", {31'd0, busy}, 32'd0);
    checkOutput("mul_done_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 3'b000, 8'h00, 8'h00, 3'd0, 1'b0);
    checkOutput("post_mul_add_regwrite", {31'd0, regwrite}, 32'd1);
    checkOutput("post_mul_add_writereg", {29'd0, writereg}, 32'd6);
    checkOutput("post_mul_add_writedata", {24'd0, writedata}, 32'h03);
    @(negedge clk);
    checkOutput("post_mul_idle_regwrite", {31'd0, regwrite}, 32'd0);

    // Multiply aborted by reset partway through: no write ever appears.
    applyStimulus(1'b1, 3'b111, 8'd3, 8'd3, 3'd1, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 3'b000, 8'h00, 8'h00, 3'd0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("abort_regwrite", {31'd0, regwrite}, 32'd0);
    reset = 1'b1;
    for (int c = 0; c < 2 * WIDTH; c++) begin
      @(negedge clk);
      checkOutput($sformatf("abort_quiet_c%0d", c), {31'd0, regwrite}, 32'd0);
    end
`endif

    // Traffic while reset is held low is ignored.
    reset = 1'b0;
    applyStimulus(1'b1, 3'b000, 8'h40, 8'h41, 3'd7, 1'b1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput($sformatf("rsttraffic_regwrite_c%0d", c), {31'd0, regwrite}, 32'd0);
      checkOutput($sformatf("rsttraffic_writedata_c%0d", c), {24'd0, writedata}, 32'd0);
      checkOutput($sformatf("rsttraffic_carry_c%0d", c), {31'd0, carry}, 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 3'b000, 8'h00, 8'h00, 3'd0, 1'b0);
    checkOutput("after_rst_writedata", {24'd0, writedata}, 32'h81);
    checkOutput("after_rst_writereg", {29'd0, writereg}, 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
